// File: rtl/riscv151_mmio_pkg.sv
// Shared constants for the MMIO responder: region select, register offsets,
// and the UART transmit state encoding.
package riscv151_mmio_pkg;

    localparam logic [3:0] IO_REGION = 4'h8;
    localparam int unsigned CNT_W_DEFAULT = 32;

    localparam logic [7:0] UART_CTRL = 8'h00;
    localparam logic [7:0] UART_RX   = 8'h04;
    localparam logic [7:0] UART_TX   = 8'h08;
    localparam logic [7:0] CYC_CNT   = 8'h10;
    localparam logic [7:0] INST_CNT  = 8'h14;
    localparam logic [7:0] CNT_RST   = 8'h18;

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_SEND = 1'b1
    } tx_state_e;

    // Word-aligned register offset; byte lane bits are don't-care.
    function automatic logic [7:0] word_offset(input logic [31:0] a);
        return {a[7:2], 2'b00};
    endfunction

endpackage

// File: rtl/mmio_io_ctrl_io_counter.sv
// Free-running event counter with synchronous clear; clear overrides increment
// and the count wraps naturally at its full width.
module io_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mmio_io_ctrl.sv
// Memory-mapped I/O responder: UART TX/RX bridge plus cycle and retired-instruction
// counters, with one-cycle registered read data like the other data memories.
module mmio_io_ctrl #(
    parameter logic [3:0]  IO_REGION = riscv151_mmio_pkg::IO_REGION,
    parameter int unsigned CNT_W     = riscv151_mmio_pkg::CNT_W_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  we,
    input  logic        re,
    output logic [31:0] rdata,
    input  logic        inst_retire,
    output logic [7:0]  uart_tx_data,
    output logic        uart_tx_valid,
    input  logic        uart_tx_ready,
    input  logic [7:0]  uart_rx_data,
    input  logic        uart_rx_valid,
    output logic        uart_rx_ready
);

    import riscv151_mmio_pkg::*;

    logic             sel;
    logic [7:0]       off;
    logic             store;
    logic             cnt_clr;
    logic             tx_start;
    tx_state_e        tx_state;
    logic [CNT_W-1:0] cyc_count;
    logic [CNT_W-1:0] inst_count;
    logic [31:0]      rd_mux;
    logic             unused_bits;

    assign sel      = (addr[31:28] == IO_REGION);
    assign off      = word_offset(addr);
    assign store    = sel && (we != 4'b0000);
    assign cnt_clr  = store && (off == CNT_RST);
    assign tx_start = store && (off == UART_TX) && we[0];

    assign unused_bits = ^{addr[27:8], addr[1:0], wdata[31:8]};

    io_counter #(.CNT_W(CNT_W)) u_cyc_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (1'b1),
        .count (cyc_count)
    );

    io_counter #(.CNT_W(CNT_W)) u_inst_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (inst_retire),
        .count (inst_count)
    );

    // The pop is acknowledged in the same cycle as the load so the UART can
    // advance its buffer while rdata captures the current byte.
    assign uart_rx_ready = re && sel && (off == UART_RX) && uart_rx_valid;

    always_comb begin
        rd_mux = '0;
        case (off)
            UART_CTRL: rd_mux = {30'b0, uart_rx_valid,
                                 (tx_state == TX_IDLE) && uart_tx_ready};
            UART_RX:   rd_mux = {24'b0, uart_rx_data};
            CYC_CNT:   rd_mux = 32'(cyc_count);
            INST_CNT:  rd_mux = 32'(inst_count);
            default:   rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= sel ? rd_mux : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state      <= TX_IDLE;
            uart_tx_valid <= 1'b0;
            uart_tx_data  <= '0;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    if (tx_start) begin
                        uart_tx_data  <= wdata[7:0];
                        uart_tx_valid <= 1'b1;
                        tx_state      <= TX_SEND;
                    end
                end
                TX_SEND: begin
                    // Stores to the TX register here are ignored; the byte stays put.
                    if (uart_tx_ready) begin
                        uart_tx_valid <= 1'b0;
                        tx_state      <= TX_IDLE;
                    end
                end
                default: begin
                    uart_tx_valid <= 1'b0;
                    tx_state      <= TX_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_io_ctrl.sv
// Scoreboard bench for mmio_io_ctrl: a 32-bit instance plus a 4-bit-counter
// instance sharing the same inputs, so counter wrap is observable in few cycles.
module tb_mmio_io_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  we;
    logic        re;
    logic        inst_retire;
    logic        uart_tx_ready;
    logic [7:0]  uart_rx_data;
    logic        uart_rx_valid;

    logic [31:0] rdata,  rdata_w;
    logic [7:0]  tx_data, tx_data_w;
    logic        tx_valid, tx_valid_w;
    logic        rx_ready, rx_ready_w;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] exp;
        logic [31:0] exp_w;
        string       name;
    } rd_exp_t;

    rd_exp_t    rd_q[$];
    logic [7:0] tx_q[$];

    always #5 clk = ~clk;

    mmio_io_ctrl #(.IO_REGION(4'h8), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .we(we), .re(re),
        .rdata(rdata), .inst_retire(inst_retire),
        .uart_tx_data(tx_data), .uart_tx_valid(tx_valid), .uart_tx_ready(uart_tx_ready),
        .uart_rx_data(uart_rx_data), .uart_rx_valid(uart_rx_valid), .uart_rx_ready(rx_ready)
    );

    mmio_io_ctrl #(.IO_REGION(4'h8), .CNT_W(4)) dut_w (
        .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .we(we), .re(re),
        .rdata(rdata_w), .inst_retire(inst_retire),
        .uart_tx_data(tx_data_w), .uart_tx_valid(tx_valid_w), .uart_tx_ready(uart_tx_ready),
        .uart_rx_data(uart_rx_data), .uart_rx_valid(uart_rx_valid), .uart_rx_ready(rx_ready_w)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] e,
                      input logic [31:0] ew, input string name);
        rd_exp_t x;
        addr = a; we = 4'b0000; re = 1'b1;
        x.exp = e; x.exp_w = ew; x.name = name;
        rd_q.push_back(x);
        cyc();
        re = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        addr = a; wdata = d; we = be; re = 1'b0;
        cyc();
        we = 4'b0000;
    endtask

    // Read-data monitor: a load accepted at one edge is checked mid-way through the next cycle.
    initial begin
        logic pend;
        rd_exp_t x;
        forever begin
            @(posedge clk);
            pend = re && !rst;
            @(negedge clk);
            if (pend) begin
                if (rd_q.size() == 0) begin
                    check("rd_unexpected", rdata, 32'hxxxx_xxxx);
                end else begin
                    x = rd_q.pop_front();
                    check(x.name, rdata, x.exp);
                    check({x.name, "_w4"}, rdata_w, x.exp_w);
                end
            end
        end
    end

    // TX monitor: every handshake must match the next byte software was allowed to send.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && tx_valid && uart_tx_ready) begin
                if (tx_q.size() == 0) begin
                    check("tx_unexpected", {24'b0, tx_data}, 32'hxxxx_xxxx);
                end else begin
                    check("tx_byte", {24'b0, tx_data}, {24'b0, tx_q.pop_front()});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; addr = '0; wdata = '0; we = 4'b0000; re = 1'b0;
        inst_retire = 1'b0; uart_tx_ready = 1'b0; uart_rx_data = 8'h00; uart_rx_valid = 1'b0;

        // 1: reset and counter reads
        cyc();
        rst = 1'b0;
        check("rst_rdata",    rdata, 32'h0);
        check("rst_tx_valid", {31'b0, tx_valid}, 32'h0);
        check("rst_tx_data",  {24'b0, tx_data}, 32'h0);
        check("rst_rx_ready", {31'b0, rx_ready}, 32'h0);
        rd(32'h8000_0010, 32'h0, 32'h0, "rst_cyc_cnt");
        rd(32'h8000_0014, 32'h0, 32'h0, "rst_inst_cnt");

        // 2/3: transmit with back-pressure, drop a store while busy
        uart_tx_ready = 1'b0;
        tx_q.push_back(8'h41);
        wr(32'h8000_0008, 32'h0000_0041, 4'b0001);
        check("send_valid0", {31'b0, tx_valid}, 32'h1);
        check("send_data0",  {24'b0, tx_data}, 32'h41);
        wr(32'h8000_0008, 32'h0000_0042, 4'b0001);
        check("send_valid1", {31'b0, tx_valid}, 32'h1);
        check("send_data1",  {24'b0, tx_data}, 32'h41);
        rd(32'h8000_0000, 32'h0, 32'h0, "status_busy");
        check("send_valid2", {31'b0, tx_valid}, 32'h1);
        check("send_data2",  {24'b0, tx_data}, 32'h41);
        cyc();
        check("send_valid3", {31'b0, tx_valid}, 32'h1);
        uart_tx_ready = 1'b1;
        cyc();
        check("tx_idle_after_hs", {31'b0, tx_valid}, 32'h0);
        rd(32'h8000_0000, 32'h1, 32'h1, "status_idle");
        tx_q.push_back(8'h43);
        wr(32'h8000_0008, 32'hFFFF_FF43, 4'b0001);
        check("send43_valid", {31'b0, tx_valid}, 32'h1);
        check("send43_data",  {24'b0, tx_data}, 32'h43);
        cyc();
        check("send43_done", {31'b0, tx_valid}, 32'h0);
        wr(32'h8000_0008, 32'h0000_0077, 4'b0010);
        check("tx_needs_we0", {31'b0, tx_valid}, 32'h0);
        wr(32'h1000_0008, 32'h0000_0055, 4'b1111);
        check("tx_out_of_region", {31'b0, tx_valid}, 32'h0);

        // 4: receive path
        uart_tx_ready = 1'b0;
        uart_rx_data = 8'h5A; uart_rx_valid = 1'b1;
        rd(32'h8000_0000, 32'h2, 32'h2, "status_rx");
        addr = 32'h8000_0004; re = 1'b1;
        #1;
        check("rx_pop_pulse", {31'b0, rx_ready}, 32'h1);
        #(-0);
        re = 1'b0;
        rd_q.push_back('{32'h0000_005A, 32'h0000_005A, "rx_data"});
        re = 1'b1;
        @(posedge clk); #1;
        re = 1'b0;
        #1;
        check("rx_pop_single", {31'b0, rx_ready}, 32'h0);
        uart_rx_valid = 1'b0;
        addr = 32'h8000_0004; re = 1'b1;
        #1;
        check("rx_no_pop", {31'b0, rx_ready}, 32'h0);
        rd_q.push_back('{32'h0000_005A, 32'h0000_005A, "rx_data_novalid"});
        @(posedge clk); #1;
        re = 1'b0;

        // 5: counters, clear, wrap (4-bit instance) and clear-wins
        inst_retire = 1'b0;
        wr(32'h8000_0018, 32'h0, 4'b1111);
        for (int i = 0; i < 100; i++) begin
            inst_retire = (i % 2 == 0);
            cyc();
        end
        inst_retire = 1'b0;
        rd(32'h8000_0010, 32'd100, 32'd4, "cyc_cnt_100");
        rd(32'h8000_0014, 32'd50,  32'd2, "inst_cnt_50");
        inst_retire = 1'b1;
        wr(32'h8000_001A, 32'h0, 4'b0100);
        inst_retire = 1'b0;
        rd(32'h8000_0010, 32'd0, 32'd0, "cyc_cnt_clr");
        rd(32'h8000_0014, 32'd0, 32'd0, "inst_cnt_clr_wins");
        wr(32'h1000_0018, 32'h0, 4'b1111);
        rd(32'h8000_0010, 32'd3, 32'd3, "cyc_cnt_no_foreign_clr");
        repeat (14) cyc();
        rd(32'h8000_0010, 32'd18, 32'd2, "cyc_cnt_wrap_w4");

        // 6: unmapped reads, reset while sending
        rd(32'h8000_0020, 32'h0, 32'h0, "unmapped_off");
        uart_rx_data = 8'hA5; uart_rx_valid = 1'b1;
        rd(32'h8000_0004, 32'hA5, 32'hA5, "rx_before_rst");
        rd(32'h1000_0000, 32'h0, 32'h0, "outside_region");
        rd(32'h8000_0004, 32'hA5, 32'hA5, "rx_before_rst2");
        wr(32'h8000_0008, 32'h0000_0044, 4'b0001);
        check("send44_valid", {31'b0, tx_valid}, 32'h1);
        check("hold_rdata", rdata, 32'hA5);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        check("rst_send_valid",    {31'b0, tx_valid}, 32'h0);
        check("rst_send_data",     {24'b0, tx_data}, 32'h0);
        check("rst_send_rdata",    rdata, 32'h0);
        check("rst_send_rx_ready", {31'b0, rx_ready}, 32'h0);
        uart_tx_ready = 1'b1;
        uart_rx_valid = 1'b0;
        repeat (3) cyc();
        check("abandoned_stays_idle", {31'b0, tx_valid}, 32'h0);

        repeat (2) cyc();
        check("rd_queue_drained", rd_q.size(), 32'd0);
        check("tx_queue_drained", tx_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
